// File: rtl/wide_alu_seq_if.sv
// wide_alu_seq_if: byte-wide bus between the 16-bit sequencer (master) and the
// shared combinational 8-bit ALU (slave).
interface wide_alu_seq_if;
  logic [3:0] alu_cmd;
  logic [7:0] alu_inA;
  logic [7:0] alu_inB;
  logic       alu_sc_i;
  logic [7:0] alu_rslt;
  logic       alu_sc_o;

  modport master (
    output alu_cmd, alu_inA, alu_inB, alu_sc_i,
    input  alu_rslt, alu_sc_o
  );

  modport slave (
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i,
    output alu_rslt, alu_sc_o
  );
endinterface

// File: rtl/wide_alu_seq.sv
// wide_alu_seq: runs one 16-bit operation as two byte steps on a shared 8-bit
// ALU (IDLE -> FIRST -> SECOND -> DONE). Carry/shift bits chain between steps.
// Optional feature macro: WIDE_ALU_SEQ_CIN_EN adds a cin input used as the
// first-step carry/shift-in for add and lsh (0 when the macro is undefined).
module wide_alu_seq (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic [15:0]    a,
  input  logic [15:0]    b,
`ifdef WIDE_ALU_SEQ_CIN_EN
  input  logic           cin,
`endif
  wide_alu_seq_if.master alu,
  output logic           busy,
  output logic           done,
  output logic [15:0]    result,
  output logic           carry,
  output logic           zero,
  output logic           err
);

  // Operation codes double as ALU commands.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LSH = 4'd2;
  localparam logic [3:0] OP_ASR = 4'd3;
  localparam logic [3:0] OP_LSR = 4'd4;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic        cin_in;
  logic        hi_first, sel_hi, logic_op;
  logic [7:0]  a_byte, b_byte;
  logic [3:0]  cmd_s;
  logic [7:0]  ina_s, inb_s;
  logic        sci_s;

`ifdef WIDE_ALU_SEQ_CIN_EN
  assign cin_in = cin;
`else
  assign cin_in = 1'b0;
`endif

  function automatic logic op_legal(input logic [3:0] o);
    case (o)
      OP_ADD, OP_SUB, OP_LSH, OP_ASR, OP_LSR, OP_AND, OP_XOR: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // Right shifts must start at the high byte so its LSB can feed the low byte.
  assign hi_first = (op_q == OP_ASR) || (op_q == OP_LSR);
  assign logic_op = (op_q == OP_AND) || (op_q == OP_XOR);
  assign sel_hi   = (state_q == S_FIRST) ? hi_first : ~hi_first;
  assign a_byte   = sel_hi ? a_q[15:8] : a_q[7:0];
  assign b_byte   = sel_hi ? b_q[15:8] : b_q[7:0];

  // ALU drive for the current byte step; all zero outside FIRST/SECOND.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cmd_s = 4'd0;
    ina_s = 8'd0;
    inb_s = 8'd0;
    sci_s = 1'b0;
    if (state_q == S_FIRST || state_q == S_SECOND) begin
      ina_s = a_byte;
      inb_s = (op_q == OP_SUB) ? ~b_byte : b_byte;
      case (op_q)
        OP_ADD, OP_SUB: cmd_s = OP_ADD;
        OP_ASR:         cmd_s = (state_q == S_FIRST) ? OP_ASR : OP_LSR;
        default:        cmd_s = op_q;
      endcase
      if (state_q == S_FIRST) begin
        case (op_q)
          OP_ADD, OP_LSH: sci_s = cin_q;
          OP_SUB:         sci_s = 1'b1;
          default:        sci_s = 1'b0;
        endcase
      end else begin
        sci_s = logic_op ? 1'b0 : carry_q;
      end
    end
  end

  assign alu.alu_cmd  = cmd_s;
  assign alu.alu_inA  = ina_s;
  assign alu.alu_inB  = inb_s;
  assign alu.alu_sc_i = sci_s;

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          cin_d = cin_in;
          err_d = 1'b0;
          if (op_legal(op)) begin
            state_d = S_FIRST;
          end else begin
            state_d  = S_DONE;
            result_d = 16'h0000;
            carry_d  = 1'b0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      S_FIRST, S_SECOND: begin
        if (sel_hi) result_d[15:8] = alu.alu_rslt;
        else        result_d[7:0]  = alu.alu_rslt;
        carry_d = logic_op ? 1'b0 : alu.alu_sc_o;
        zero_d  = (result_d == 16'h0000);
        state_d = (state_q == S_FIRST) ? S_SECOND : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and outcome registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      cin_q    <= 1'b0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_wide_alu_seq.sv
// tb_wide_alu_seq: randomized and directed operations on wide_alu_seq with a
// byte ALU model attached; a scoreboard of 16-bit reference results is
// checked by an independent monitor on every done pulse.
module tb_wide_alu_seq;

`ifdef WIDE_ALU_SEQ_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        cin;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, carry, zero, err;
  logic [15:0] result;

  wide_alu_seq_if alu_bus ();

  wide_alu_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
`ifdef WIDE_ALU_SEQ_CIN_EN
    .cin     (cin),
`endif
    .alu     (alu_bus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .zero    (zero),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Shared 8-bit ALU: combinational, single-bit shifts of inA.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_bus.alu_inA} + {1'b0, alu_bus.alu_inB} + {8'd0, alu_bus.alu_sc_i};
    alu_bus.alu_rslt = 8'd0;
    alu_bus.alu_sc_o = 1'b0;
    case (alu_bus.alu_cmd)
      4'd0: begin alu_bus.alu_rslt = alu_sum[7:0]; alu_bus.alu_sc_o = alu_sum[8]; end
      4'd2: begin alu_bus.alu_rslt = {alu_bus.alu_inA[6:0], alu_bus.alu_sc_i}; alu_bus.alu_sc_o = alu_bus.alu_inA[7]; end
      4'd3: begin alu_bus.alu_rslt = {alu_bus.alu_inA[7], alu_bus.alu_inA[7:1]}; alu_bus.alu_sc_o = alu_bus.alu_inA[0]; end
      4'd4: begin alu_bus.alu_rslt = {alu_bus.alu_sc_i, alu_bus.alu_inA[7:1]}; alu_bus.alu_sc_o = alu_bus.alu_inA[0]; end
      4'd6: alu_bus.alu_rslt = alu_bus.alu_inA & alu_bus.alu_inB;
      4'd7: alu_bus.alu_rslt = alu_bus.alu_inA ^ alu_bus.alu_inB;
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 16-bit reference: the whole operation in one step of plain arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv);
    exp_t        e;
    logic [16:0] s;
    e.err = 1'b0;
    e.done_cyc = 0;
    case (o)
      4'd0:    s = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
      4'd1:    s = {1'b0, av} + {1'b0, ~bv} + 17'd1;
      4'd2:    s = {av, cv};
      4'd3:    s = {av[0], av[15], av[15:1]};
      4'd4:    s = {av[0], 1'b0, av[15:1]};
      4'd6:    s = {1'b0, av & bv};
      4'd7:    s = {1'b0, av ^ bv};
      default: begin s = 17'd0; e.err = 1'b1; end
    endcase
    e.result = s[15:0];
    e.carry  = s[16];
    e.zero   = (s[15:0] == 16'h0000);
    return e;
  endfunction

  // Monitor: scoreboard compare on done, hold and bus-idle checks otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b0) begin
      sb.delete();
      last = '{16'h0000, 1'b0, 1'b0, 1'b0, 0};
    end
    if (done === 1'b1) begin
      check("alu_bus_done", {alu_bus.alu_cmd, alu_bus.alu_inA, alu_bus.alu_inB, alu_bus.alu_sc_i}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("result", {16'd0, result}, {16'd0, e.result});
        check("carry", {31'd0, carry}, {31'd0, e.carry});
        check("zero", {31'd0, zero}, {31'd0, e.zero});
        check("err", {31'd0, err}, {31'd0, e.err});
        last = e;
      end
    end else if (busy === 1'b0) begin
      check("alu_bus_idle", {alu_bus.alu_cmd, alu_bus.alu_inA, alu_bus.alu_inB, alu_bus.alu_sc_i}, 32'd0);
      check("hold_result", {16'd0, result}, {16'd0, last.result});
      check("hold_flags", {29'd0, carry, zero, err}, {29'd0, last.carry, last.zero, last.err});
    end
  end

  // Issue one operation at a negedge once the DUT is idle; returns one cycle later.
  task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv, input logic cv);
    exp_t e;
    int   n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_wait", {31'd0, busy}, 32'd0);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    cin   = cv;
    e = model(o, av, bv, CIN_EN ? cv : 1'b0);
    e.done_cyc = cyc + (e.err ? 1 : 3);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pulse start with other operands while the DUT is busy.
  task automatic junk_start();
    start = 1'b1;
    op    = 4'd0;
    a     = 16'h1234;
    b     = 16'h4321;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [3:0] legal_ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
  logic [3:0] bad_ops   [9] = '{4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    int          n;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    a       = 16'h0000;
    b       = 16'h0000;
    cin     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, carry, zero, err, result}, 21'd0);
    check("rst_alu_bus", {alu_bus.alu_cmd, alu_bus.alu_inA, alu_bus.alu_inB, alu_bus.alu_sc_i}, 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    issue(4'd0, 16'h00FF, 16'h0001, 1'b0);
    issue(4'd1, 16'h0100, 16'h0001, 1'b0);
    issue(4'd1, 16'h0000, 16'h0001, 1'b0);
    issue(4'd3, 16'h8001, 16'h0000, 1'b0);
    issue(4'd2, 16'h8080, 16'h0000, 1'b0);
    issue(4'd4, 16'h8001, 16'h0000, 1'b0);
    issue(4'd7, 16'hFFFF, 16'hFFFF, 1'b0);
    issue(4'd6, 16'hF0F0, 16'h0FF0, 1'b0);
    issue(4'd5, 16'h1234, 16'h5678, 1'b0);
    // Start pulsed during FIRST must be ignored.
    issue(4'd0, 16'h1111, 16'h2222, 1'b0);
    junk_start();
    issue(4'd1, 16'h0005, 16'h0003, 1'b0);

    // Reset during SECOND: everything clears, no done for the lost operation.
    issue(4'd0, 16'hABCD, 16'h1111, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, carry, zero, err, result}, 21'd0);
    check("midrst_alu_bus", {alu_bus.alu_cmd, alu_bus.alu_inA, alu_bus.alu_inB, alu_bus.alu_sc_i}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    issue(4'd0, 16'h00FF, 16'h0001, 1'b1);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) ro = bad_ops[$urandom_range(0, 8)];
      else                           ro = legal_ops[$urandom_range(0, 6)];
      case ($urandom_range(0, 5))
        0:       ra = 16'h0000;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = ra;
        1:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      issue(ro, ra, rb, 1'($urandom));
      if ($urandom_range(0, 7) == 0) junk_start();
    end

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_alu_seq.md
WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: request a 16-bit operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 4: operation code, same encoding as the ALU command (0 add, 1 sub, 2 lsh, 3 asr, 4 lsr, 6 and, 7 xor).
REQ-005 SHALL have ports a and b, input, 16 each: operands.
REQ-006 SHALL have port alu_cmd, output, 4: command driven to the shared 8-bit ALU.
REQ-007 SHALL have ports alu_inA and alu_inB, output, 8 each: ALU operand bytes.
REQ-008 SHALL have port alu_sc_i, output, 1: ALU shift/carry in.
REQ-009 SHALL have ports alu_rslt, input, 8, and alu_sc_o, input, 1: ALU result and carry out, combinational from the above.
REQ-010 SHALL have port busy, output, 1: high in any non-IDLE state.
REQ-011 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-012 SHALL have ports result, output, 16; carry, output, 1; zero, output, 1; err, output, 1: registered outcome, held until the next accepted start.

Function
REQ-013 SHALL implement FSM IDLE -> FIRST -> SECOND -> DONE -> IDLE, one cycle per state except IDLE.
REQ-014 SHALL, in IDLE with start=1, register op, a and b, clear err, and go to FIRST; an illegal op (5, 8-15) SHALL go straight to DONE with result=0, carry=0, err=1.
REQ-015 SHALL ignore start whenever busy=1; latched operands SHALL NOT change.
REQ-016 SHALL process the low byte first for add, sub, lsh, and, xor, and the high byte first for asr and lsr.
REQ-017 SHALL drive add as alu_cmd=0: first alu_sc_i=cin, second alu_sc_i=carry captured from first.
REQ-018 SHALL drive sub as alu_cmd=0 with alu_inB=~b byte: first alu_sc_i=1, second chained; carry=1 means no borrow.
REQ-019 SHALL drive lsh as alu_cmd=2: first alu_sc_i=cin, second chained.
REQ-020 SHALL drive asr as alu_cmd=3 on the high byte, then alu_cmd=4 on the low byte with alu_sc_i=carry from the high byte; lsr SHALL use alu_cmd=4 for both bytes, first alu_sc_i=0.
REQ-021 SHALL drive and/xor per byte with alu_sc_i=0; final carry SHALL be 0.
REQ-022 SHALL capture alu_rslt into the matching result byte at the end of FIRST and SECOND; final carry SHALL be alu_sc_o of the SECOND step.
REQ-023 SHALL assert done for exactly the DONE cycle; result, carry and zero SHALL be valid in that cycle; done SHALL therefore rise 3 cycles after the start edge (legal ops).
REQ-024 SHALL set zero=1 iff result==16'h0000, registered with result.
REQ-025 SHALL drive alu_cmd, alu_inA, alu_inB, alu_sc_i to 0 in IDLE and DONE.
REQ-026 SHALL accept a new start in the cycle after DONE (back-to-back throughput 4 cycles).

Reset
REQ-027 SHALL, on reset_n low at any time, including mid-operation, enter IDLE immediately and clear result, carry, zero, err, done, busy and all ALU drive outputs to 0.
REQ-028 SHALL discard an in-flight operation on reset and SHALL NOT emit done for it.

Configuration
REQ-029 SHALL support macro WIDE_ALU_SEQ_CIN_EN: when defined, adds input cin (1 bit) sampled with start and used as the first-step alu_sc_i for add and lsh; when undefined, no cin port and that value SHALL be 0.

Verification
REQ-030 SHALL test add a=16'h00FF, b=16'h0001 -> result 16'h0100, carry 0, zero 0, done 3 cycles after start.
REQ-031 SHALL test sub 16'h0100-16'h0001 -> 16'h00FF, carry 1; sub 16'h0000-16'h0001 -> 16'hFFFF, carry 0.
REQ-032 SHALL test asr a=16'h8001 -> 16'hC000, carry 1; lsh a=16'h8080 -> 16'h0100, carry 1.
REQ-033 SHALL test start pulsed during FIRST with different operands -> ignored, original result delivered, one done only.
REQ-034 SHALL test op=5 -> done 1 cycle after start, err 1, result 0; and xor 16'hFFFF^16'hFFFF -> 0, zero 1.
REQ-035 SHALL test reset_n low during SECOND -> all outputs 0, no done; the next start completes normally.
